// File: rtl/vmem_pkg.sv
// vmem_pkg: shared types and constants for the vector memory-stage unit.
//   state_t     - access FSM states (IDLE, ACCESS, DONE)
//   TIMEOUT     - wait cycles without an ack before abandoning a beat
//                 (only used when VMEM_TIMEOUT_EN is defined)
//   calc_lanes  - number of N-bit lanes in a V-bit vector
package vmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned TIMEOUT = 255;

  function automatic int unsigned calc_lanes(input int unsigned v, input int unsigned n);
    return v / n;
  endfunction

endpackage

// File: rtl/vec_mem_unit_if.sv
// vec_mem_unit_if: 32-bit data-memory req/ack bus.
//   mem_req   - request valid, held until mem_ack
//   mem_we    - 1 = write
//   mem_addr  - word address
//   mem_wdata - write data
//   mem_ack   - request accepted/completed this cycle
//   mem_rdata - read data, valid with mem_ack
// master = access unit, slave = memory.
interface vec_mem_unit_if #(
  parameter int unsigned N = 32
);

  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ack;
  logic [N-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/register.sv
// register: N-bit capture register with synchronous active-high reset.
//   clk, rst - clock, reset (q cleared to 0)
//   wen      - capture strobe; q <= d when high
//   d, q     - data in / held value
module register #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vec_mem_unit.sv
// vec_mem_unit: memory-stage access unit. Performs scalar accesses and
// vector gather/scatter (one N-bit word per lane, lane 0 first) against a
// req/ack data memory and stalls the upstream pipeline until done.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   regw_M/memw_M/regmem_M    - M-stage controls (store has priority over load)
//   vec_M                     - 1 = vector access
//   regScr_M                  - destination index, returned on regScr_out
//   ALUrslt_M / address_M     - scalar store data / address
//   regrsltV_M / v_address_M  - per-lane store data / addresses
//   mem                       - memory bus (vec_mem_unit_if.master)
//   stall                     - combinational hold for IF..EM registers
//   ld_data / ld_dataV        - last scalar / vector load result
//   op_done                   - one-cycle pulse when an operation finishes
//   regScr_out                - destination index of the finished operation
//   err                       - sticky timeout flag (VMEM_TIMEOUT_EN only)
// Build option: define VMEM_TIMEOUT_EN to abandon a beat after TIMEOUT
// cycles without mem_ack and raise err.
import vmem_pkg::*;

module vec_mem_unit #(
  parameter int unsigned V = 128,
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regw_M,
  input  logic          memw_M,
  input  logic          regmem_M,
  input  logic          vec_M,
  input  logic [M-1:0]  regScr_M,
  input  logic [N-1:0]  ALUrslt_M,
  input  logic [N-1:0]  address_M,
  input  logic [V-1:0]  regrsltV_M,
  input  logic [V-1:0]  v_address_M,
  vec_mem_unit_if.master mem,
  output logic          stall,
  output logic [N-1:0]  ld_data,
  output logic [V-1:0]  ld_dataV,
  output logic          op_done,
  output logic [M-1:0]  regScr_out
`ifdef VMEM_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  localparam int unsigned LANES = calc_lanes(V, N);
  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_req;
  logic               w_cap;
  logic               w_last;
  logic               w_we_cap;
  logic               w_vec_cap;
  logic [1:0]         w_ctl_cap;
  logic [N-1:0]       w_addr_cap;
  logic [N-1:0]       w_data_cap;
  logic [V-1:0]       w_vaddr_cap;
  logic [V-1:0]       w_vdata_cap;
  logic               w_timeout;
  logic               w_unused_ok;

  // regw_M only travels with the instruction; the unit never acts on it
  assign w_unused_ok = regw_M;

  assign w_req = memw_M | regmem_M;
  assign w_cap = (r_state == IDLE) && w_req;

  // Operand capture, frozen for the whole operation
  register #(.N(2)) u_cap_ctl (
    .clk(clk), .rst(rst), .wen(w_cap), .d({memw_M, vec_M}), .q(w_ctl_cap)
  );
  register #(.N(N)) u_cap_addr (
    .clk(clk), .rst(rst), .wen(w_cap), .d(address_M), .q(w_addr_cap)
  );
  register #(.N(N)) u_cap_data (
    .clk(clk), .rst(rst), .wen(w_cap), .d(ALUrslt_M), .q(w_data_cap)
  );
  register #(.N(V)) u_cap_vaddr (
    .clk(clk), .rst(rst), .wen(w_cap), .d(v_address_M), .q(w_vaddr_cap)
  );
  register #(.N(V)) u_cap_vdata (
    .clk(clk), .rst(rst), .wen(w_cap), .d(regrsltV_M), .q(w_vdata_cap)
  );
  register #(.N(M)) u_cap_dst (
    .clk(clk), .rst(rst), .wen(w_cap), .d(regScr_M), .q(regScr_out)
  );

  assign w_we_cap  = w_ctl_cap[1];
  assign w_vec_cap = w_ctl_cap[0];
  assign w_last    = w_vec_cap ? (r_cnt == CNT_W'(LANES - 1)) : 1'b1;

`ifdef VMEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] r_wait;

  // r_wait holds the waits already spent on this beat; this cycle is one more
  assign w_timeout = (r_state == ACCESS) && !mem.mem_ack &&
                     (r_wait == WAIT_W'(TIMEOUT - 1));

  // Wait counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      err    <= 1'b0;
    end else begin
      if (w_cap || mem.mem_ack || r_state != ACCESS) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and bus/pipeline outputs
  always_comb begin
    w_next        = r_state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = w_vec_cap ? w_vaddr_cap[r_cnt*N +: N] : w_addr_cap;
    mem.mem_wdata = w_vec_cap ? w_vdata_cap[r_cnt*N +: N] : w_data_cap;
    stall         = 1'b0;
    op_done       = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_req;
        if (w_req) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = w_we_cap;
        if ((mem.mem_ack && w_last) || w_timeout) begin
          w_next = DONE;
        end
      end
      DONE: begin
        op_done = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Lane counter and load result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      ld_data  <= '0;
      ld_dataV <= '0;
    end else if (w_cap) begin
      r_cnt <= '0;
      // A load starts from a clean result so unfilled lanes read 0
      if (!memw_M) begin
        if (vec_M) begin
          ld_dataV <= '0;
        end else begin
          ld_data <= '0;
        end
      end
    end else if (r_state == ACCESS && mem.mem_ack) begin
      if (!w_we_cap) begin
        if (w_vec_cap) begin
          ld_dataV[r_cnt*N +: N] <= mem.mem_rdata;
        end else begin
          ld_data <= mem.mem_rdata;
        end
      end
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_unit.sv
// tb_vec_mem_unit: directed bench for vec_mem_unit. Memory model returns
// addr+0x100 on reads after a programmable number of wait cycles and logs
// every write beat; ops are applied from a table and hold while stall=1.
module tb_vec_mem_unit;

  localparam int unsigned V = 128;
  localparam int unsigned N = 32;
  localparam int unsigned M = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          regw_M, memw_M, regmem_M, vec_M;
  logic [M-1:0]  regScr_M;
  logic [N-1:0]  ALUrslt_M, address_M;
  logic [V-1:0]  regrsltV_M, v_address_M;
  logic          stall, op_done;
  logic [N-1:0]  ld_data;
  logic [V-1:0]  ld_dataV;
  logic [M-1:0]  regScr_out;
`ifdef VMEM_TIMEOUT_EN
  logic          err;
`endif

  vec_mem_unit_if #(.N(N)) mif ();

  vec_mem_unit #(.V(V), .N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M), .vec_M(vec_M),
    .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .address_M(address_M),
    .regrsltV_M(regrsltV_M), .v_address_M(v_address_M),
    .mem(mif),
    .stall(stall), .ld_data(ld_data), .ld_dataV(ld_dataV),
    .op_done(op_done), .regScr_out(regScr_out)
`ifdef VMEM_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  logic [N-1:0] wq_a[$];
  logic [N-1:0] wq_d[$];

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_delay wait cycles, log writes, check hold
  initial begin
    int wcnt;
    logic p_wait;
    logic [N-1:0] p_addr, p_data;
    logic p_we;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    wcnt   = 0;
    p_wait = 1'b0;
    p_addr = '0;
    p_data = '0;
    p_we   = 1'b0;
    forever begin
      @(negedge clk);
      if (p_wait && mif.mem_req && !rst) begin
        chk("addr_stable", V'(mif.mem_addr), V'(p_addr));
        chk("wdata_stable", V'(mif.mem_wdata), V'(p_data));
        chk("we_stable", V'(mif.mem_we), V'(p_we));
      end
      if (mif.mem_req) begin
        if (wcnt >= ack_delay) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mif.mem_addr + 32'h100;
          if (mif.mem_we) begin
            wq_a.push_back(mif.mem_addr);
            wq_d.push_back(mif.mem_wdata);
          end
          wcnt = 0;
        end else begin
          mif.mem_ack   = 1'b0;
          mif.mem_rdata = 32'hBAD0_0000;
          wcnt++;
        end
      end else begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'hBAD0_0000;
        wcnt = 0;
      end
      p_wait = mif.mem_req && !mif.mem_ack;
      p_addr = mif.mem_addr;
      p_data = mif.mem_wdata;
      p_we   = mif.mem_we;
    end
  end

  typedef struct {
    logic         st;
    logic         ld;
    logic         vec;
    logic [N-1:0] addr;
    logic [N-1:0] data;
    logic [V-1:0] vaddr;
    logic [V-1:0] vdata;
    logic [M-1:0] dst;
    int           delay;
    int           exp_stall;
    logic [N-1:0] exp_ld;
    logic [V-1:0] exp_ldv;
  } vec_t;

  task automatic clear_inputs();
    regw_M = 1'b0; memw_M = 1'b0; regmem_M = 1'b0; vec_M = 1'b0;
    regScr_M = '0; ALUrslt_M = '0; address_M = '0;
    regrsltV_M = '0; v_address_M = '0;
  endtask

  // Runs one held instruction; returns at negedge+1 of the cycle after DONE
  task automatic run_op(input string nm, input int exp_stall, input int limit);
    int  stall_cyc;
    bit  got;
    stall_cyc = 0;
    got = 1'b0;
    for (int c = 0; c < limit; c++) begin
      #1;
      if (op_done) begin
        chk({nm, "_done_cycle"}, V'(c), V'(exp_stall));
        chk({nm, "_stall_at_done"}, V'(stall), V'(0));
        got = 1'b1;
        break;
      end
      if (stall) stall_cyc++;
      @(negedge clk);
    end
    clear_inputs();
    chk({nm, "_done_seen"}, V'(got), V'(1));
    chk({nm, "_stall_cycles"}, V'(stall_cyc), V'(exp_stall));
    @(negedge clk);
    #1;
    chk({nm, "_idle_gap_stall"}, V'(stall), V'(0));
    chk({nm, "_idle_gap_done"}, V'(op_done), V'(0));
  endtask

  vec_t tv[7];

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, '0, '0, 4'h3, 0, 2,
              32'h0, 128'h0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0,
              {32'h0C, 32'h08, 32'h04, 32'h00}, '0, 4'h5, 0, 5,
              32'h0, {32'h10C, 32'h108, 32'h104, 32'h100}};
    tv[2] = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h0,
              {32'h4C, 32'h48, 32'h44, 32'h40},
              {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 4'h6, 2, 13,
              32'h0, {32'h10C, 32'h108, 32'h104, 32'h100}};
    tv[3] = '{1'b0, 1'b1, 1'b0, 32'h30, 32'h0, '0, '0, 4'h7, 1, 3,
              32'h130, {32'h10C, 32'h108, 32'h104, 32'h100}};
    tv[4] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678, '0, '0, 4'h8, 0, 2,
              32'h130, {32'h10C, 32'h108, 32'h104, 32'h100}};
    tv[5] = '{1'b0, 1'b1, 1'b0, 32'h44, 32'h0, '0, '0, 4'h9, 0, 2,
              32'h144, {32'h10C, 32'h108, 32'h104, 32'h100}};
    tv[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0,
              {32'h1C, 32'h18, 32'h14, 32'h10}, '0, 4'hA, 1, 9,
              32'h144, {32'h11C, 32'h118, 32'h114, 32'h110}};

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", V'(stall), V'(0));
    chk("rst_op_done", V'(op_done), V'(0));
    chk("rst_mem_req", V'(mif.mem_req), V'(0));
    chk("rst_mem_we", V'(mif.mem_we), V'(0));
    chk("rst_mem_addr", V'(mif.mem_addr), V'(0));
    chk("rst_mem_wdata", V'(mif.mem_wdata), V'(0));
    chk("rst_ld_data", V'(ld_data), V'(0));
    chk("rst_ld_dataV", ld_dataV, V'(0));
    chk("rst_regScr_out", V'(regScr_out), V'(0));
`ifdef VMEM_TIMEOUT_EN
    chk("rst_err", V'(err), V'(0));
`endif

    // Non-memory instruction: no stall, no access
    regw_M = 1'b1;
    regScr_M = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("nomem_stall", V'(stall), V'(0));
      chk("nomem_req", V'(mif.mem_req), V'(0));
      chk("nomem_done", V'(op_done), V'(0));
    end
    clear_inputs();

    for (int i = 0; i < 7; i++) begin
      int beats;
      string nm;
      nm = $sformatf("op%0d", i);
      wq_a.delete();
      wq_d.delete();
      ack_delay   = tv[i].delay;
      memw_M      = tv[i].st;
      regmem_M    = tv[i].ld;
      vec_M       = tv[i].vec;
      regScr_M    = tv[i].dst;
      address_M   = tv[i].addr;
      ALUrslt_M   = tv[i].data;
      v_address_M = tv[i].vaddr;
      regrsltV_M  = tv[i].vdata;
      #1;
      chk({nm, "_stall_same_cycle"}, V'(stall), V'(1));
      run_op(nm, tv[i].exp_stall, 200);
      chk({nm, "_ld_data"}, V'(ld_data), V'(tv[i].exp_ld));
      chk({nm, "_ld_dataV"}, ld_dataV, tv[i].exp_ldv);
      chk({nm, "_regScr_out"}, V'(regScr_out), V'(tv[i].dst));
      beats = tv[i].st ? (tv[i].vec ? 4 : 1) : 0;
      chk({nm, "_write_beats"}, V'(wq_a.size()), V'(beats));
      for (int b = 0; b < beats && b < wq_a.size(); b++) begin
        chk({nm, $sformatf("_wr%0d_addr", b)}, V'(wq_a[b]),
            V'(tv[i].vec ? tv[i].vaddr[b*N +: N] : tv[i].addr));
        chk({nm, $sformatf("_wr%0d_data", b)}, V'(wq_d[b]),
            V'(tv[i].vec ? tv[i].vdata[b*N +: N] : tv[i].data));
      end
    end

    // Reset during beat 2 of a vector load
    ack_delay   = 0;
    regmem_M    = 1'b1;
    vec_M       = 1'b1;
    regScr_M    = 4'hB;
    v_address_M = {32'h2C, 32'h28, 32'h24, 32'h20};
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstmid_beat2_addr", V'(mif.mem_addr), V'(32'h24));
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    chk("rstmid_mem_req", V'(mif.mem_req), V'(0));
    chk("rstmid_ld_dataV", ld_dataV, V'(0));
    chk("rstmid_op_done", V'(op_done), V'(0));
    chk("rstmid_stall", V'(stall), V'(0));
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rstmid_no_done", V'(op_done), V'(0));
      chk("rstmid_no_req", V'(mif.mem_req), V'(0));
    end

`ifdef VMEM_TIMEOUT_EN
    // Memory never acks: beat abandoned after 255 waits
    ack_delay = 1000000;
    regmem_M  = 1'b1;
    address_M = 32'h50;
    regScr_M  = 4'hC;
    run_op("timeout", 256, 400);
    chk("timeout_err", V'(err), V'(1));
    chk("timeout_ld_data", V'(ld_data), V'(0));
    repeat (3) @(negedge clk);
    #1;
    chk("timeout_err_sticky", V'(err), V'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("timeout_err_cleared", V'(err), V'(0));
    ack_delay = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_unit.md
# vec_mem_unit

Memory-stage access unit for the vector processor. It sits directly after the Execution-Memory pipeline register and consumes its M-stage outputs. It performs scalar accesses, and vector gather/scatter accesses, against a 32-bit data memory over a req/ack handshake. Vector operations are serialized into one word per lane, and `stall` holds the upstream pipeline until the access completes.

## Interface
Parameters:
- `V`, 128, vector width in bits
- `N`, 32, scalar/word width in bits; `V` must be an integer multiple of `N`
- `M`, 4, register-index width

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `regw_M`, `memw_M`, `regmem_M`  in  1 each  M-stage control: register write, memory write, load-to-register
- `vec_M`  in  1  1 = vector access, 0 = scalar access
- `regScr_M`  in  M  destination register index; passed through to `regScr_out`
- `ALUrslt_M`  in  N  scalar store data
- `address_M`  in  N  scalar address
- `regrsltV_M`  in  V  vector store data; lane i occupies `[i*N +: N]`
- `v_address_M`  in  V  per-lane addresses; lane i occupies `[i*N +: N]`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_addr`, `mem_wdata`  out  N each  request address and write data
- `mem_ack`  in  1  request accepted/completed this cycle
- `mem_rdata`  in  N  read data, valid when `mem_ack`=1
- `stall`  out  1  hold the IF..EM pipeline registers
- `ld_data`  out  N  last scalar load result
- `ld_dataV`  out  V  last vector load result
- `op_done`  out  1  one-cycle pulse when a memory operation finishes
- `regScr_out`  out  M  captured destination index of the finished operation
- `err`  out  1  sticky timeout flag; exists only with `VMEM_TIMEOUT_EN`

## Operation
- Request condition: `req = memw_M | regmem_M`.
  - `memw_M` has priority; if both are set, the operation is a store.
  - `regw_M` only passes through and never starts an access.
- Beat count: `LANES = V/N` beats when `vec_M`=1, otherwise 1 beat.
- State machine states: `IDLE`, `ACCESS`, `DONE`.
  - `IDLE`: when `req`=1, capture all M-stage inputs, clear the lane counter to 0, and go to `ACCESS`. If the access is a load, clear the target result register to 0: `ld_dataV` for a vector load, `ld_data` for a scalar load.
  - `ACCESS`: `mem_req`=1.
    - `mem_addr` is the captured lane address: `address_M` for scalar, lane `cnt` of `v_address_M` for vector.
    - `mem_wdata` is `ALUrslt_M` for scalar, lane `cnt` of `regrsltV_M` for vector.
    - `mem_we` is 1 for a store.
    - On `mem_ack`: a load writes `mem_rdata` into lane `cnt` of `ld_dataV` (vector) or into `ld_data` (scalar). If `cnt == beats-1`, go to `DONE`; otherwise increment `cnt`.
  - `DONE`: `op_done`=1 and `stall`=0, then go to `IDLE` unconditionally. The pipeline advances in this cycle, so the same instruction is never re-issued.
- `stall = (state==IDLE & req) | state==ACCESS`. This is combinational, so the pipeline freezes in the same cycle the request appears.
- Lanes are issued in ascending order, lane 0 first.
- `mem_addr`, `mem_wdata` and `mem_we` are stable while `mem_req`=1 and `mem_ack`=0.
- `ld_data`, `ld_dataV` and `regScr_out` hold their value until the next capture.
- Reset values:
  - state = `IDLE`, `cnt` = 0
  - `mem_req`, `mem_we`, `op_done`, `err` = 0
  - `mem_addr`, `mem_wdata`, `ld_data`, `ld_dataV`, `regScr_out` = 0
- Reset mid-operation: the outstanding beat is abandoned and `mem_req` drops the next cycle. No `op_done` is produced.

## Timing
- Zero-wait memory (ack in the same cycle as req):
  - scalar access: `stall` high for 2 cycles, `op_done` in cycle 3
  - vector access: `stall` high for 1+LANES cycles, then `op_done`
- Each wait cycle (`mem_ack`=0) adds one cycle.
- Back-to-back memory instructions: `IDLE` follows `DONE`, so there is one non-stalled cycle between operations.
- A non-memory instruction causes zero stall cycles.

## Configuration
- `VMEM_TIMEOUT_EN` defined:
  - A wait counter runs in `ACCESS` and clears on each `mem_ack`.
  - When it reaches `TIMEOUT` (255) cycles without an ack, set `err` (sticky until reset), drop `mem_req`, and go to `DONE`. Load lanes not yet filled stay 0.
- `VMEM_TIMEOUT_EN` undefined: no counter and no `err` port; the unit waits for `mem_ack` indefinitely.

## Structure
- Package `vmem_pkg` contains:
  - the state enum (`IDLE`, `ACCESS`, `DONE`)
  - `TIMEOUT` = 255
  - a function computing `LANES` from `V` and `N`
- Captured operands reuse the existing `register` module (N-parameterized, `wen` = capture strobe). No other sub-module.

## Test plan
- Scalar store: `memw_M`=1, `address_M`=0x10, `ALUrslt_M`=0xDEADBEEF, zero-wait ack -> one beat (`mem_we`=1, addr 0x10, data 0xDEADBEEF); `stall` high 2 cycles; `op_done` pulse.
- Vector load: addresses {0x0C,0x08,0x04,0x00} (lane3..lane0), memory returns addr+0x100 -> 4 beats in lane order 0x00, 0x04, 0x08, 0x0C; `ld_dataV` = {0x10C,0x108,0x104,0x100}.
- Wait states: vector store with `mem_ack` delayed 2 cycles per beat -> addr/data stable while waiting; `stall` high for 13 cycles.
- `memw_M`=`regmem_M`=1 together -> store performed; `ld_data` unchanged.
- `rst` asserted during beat 2 of a vector load -> `IDLE`, `mem_req`=0 next cycle, `ld_dataV` = 0, no `op_done`.
- With `VMEM_TIMEOUT_EN`, `mem_ack` tied to 0 -> `err`=1 after 255 wait cycles, then `op_done`; `err` stays 1 until `rst`.
